// File: rtl/spi_slave_top.sv
// rtl/spi_slave_top.sv - SPI slave (modes 0-3) behind the TRSQ8 4-register CPU window
// Define SPI_SLAVE_RXFIFO_EN for a 4-entry RX FIFO; otherwise RX is a single byte register.
module spi_slave_top #(
  parameter int ADDR_LSB          = 0,
  parameter int OPT_MEM_ADDR_BITS = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss_n,
  output logic       miso,
  output logic       miso_oe
);

  localparam int AW = OPT_MEM_ADDR_BITS + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   loc_addr;
  logic            unused_addr;

  logic sclk_s1, sclk_s2, sclk_d;
  logic mosi_s1, mosi_s2;
  logic ss_s1, ss_s2, ss_d;

  logic       en, cpol, cpha, ovr, txe;
  logic [7:0] tx_buf;
  logic       cpol_l, cpha_l;
  logic [7:0] sr;
  logic       miso_q;
  logic [2:0] bit_cnt;

  logic       wr_con, wr_tx, rd_act, pop, en_nxt;
  logic       sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge, ss_fall;
  logic       start, load, push, accept, overrun;
  logic [7:0] load_byte, rx_byte, rx_head, spscon, rd_data;
  logic       rxav;

  assign loc_addr    = addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
  assign unused_addr = ^addr;

  // ss_n synchroniser resets low so a select already held low at reset release is not seen as a new frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      ss_s1   <= 1'b0;
      ss_s2   <= 1'b0;
      ss_d    <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      ss_s1   <= ss_n;
      ss_s2   <= ss_s1;
      ss_d    <= ss_s2;
    end
  end

  assign wr_con = wr_en && (loc_addr == AW'(0));
  assign wr_tx  = wr_en && (loc_addr == AW'(1));
  assign rd_act = rd_en && !wr_en;
  assign pop    = rd_act && (loc_addr == AW'(2)) && rxav;
  assign en_nxt = wr_con ? din[0] : en;

  assign sclk_edge   = sclk_s2 ^ sclk_d;
  assign lead_edge   = sclk_edge && (sclk_s2 != cpol_l);
  assign trail_edge  = sclk_edge && (sclk_s2 == cpol_l);
  assign sample_edge = cpha_l ? trail_edge : lead_edge;
  assign shift_edge  = cpha_l ? lead_edge : trail_edge;
  assign ss_fall     = ss_d && !ss_s2;

  assign load_byte = txe ? 8'h00 : tx_buf;
  assign rx_byte   = {sr[6:0], mosi_s2};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    load      = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall && en) begin
          state_nxt = SHIFT;
          start     = 1'b1;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        if (ss_s2 || !en_nxt) begin
          state_nxt = IDLE;
        end else if (sample_edge && (bit_cnt == 3'd7)) begin
          push = 1'b1;
          load = 1'b1;
        end
      end
    endcase
  end

  // Shift datapath; miso_q follows the shift register MSB, updated only on shift-out edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpol_l  <= 1'b0;
      cpha_l  <= 1'b0;
      sr      <= 8'h00;
      miso_q  <= 1'b0;
      bit_cnt <= 3'd0;
    end else if (start) begin
      cpol_l  <= cpol;
      cpha_l  <= cpha;
      sr      <= load_byte;
      miso_q  <= load_byte[7];
      bit_cnt <= 3'd0;
    end else if (state == SHIFT && state_nxt == IDLE) begin
      miso_q  <= 1'b0;
      bit_cnt <= 3'd0;
    end else if (state == SHIFT) begin
      if (sample_edge) begin
        bit_cnt <= bit_cnt + 3'd1;
        sr      <= push ? load_byte : rx_byte;
      end
      if (shift_edge) miso_q <= sr[7];
    end
  end

  // A TX write in the same cycle as a load wins, so the new byte stays queued
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_buf <= 8'h00;
      txe    <= 1'b1;
    end else begin
      if (load && !txe) txe <= 1'b1;
      if (wr_tx) begin
        tx_buf <= din;
        txe    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en   <= 1'b0;
      cpol <= 1'b0;
      cpha <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      if (wr_con) begin
        en   <= din[0];
        cpol <= din[1];
        cpha <= din[2];
        if (din[6]) ovr <= 1'b0;
      end
      if (overrun) ovr <= 1'b1;
    end
  end

`ifdef SPI_SLAVE_RXFIFO_EN
  logic [7:0] rx_fifo [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] rx_cnt;
  logic       rx_full;

  assign rxav    = (rx_cnt != 3'd0);
  assign rx_full = (rx_cnt == 3'd4);
  assign rx_head = rx_fifo[rd_ptr];
  assign accept  = push && (!rx_full || pop);
  assign overrun = push && rx_full && !pop;

  always_ff @(posedge clk) begin
    if (accept) rx_fifo[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      rx_cnt <= 3'd0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 2'd1;
      if (pop)    rd_ptr <= rd_ptr + 2'd1;
      if (accept && !pop)      rx_cnt <= rx_cnt + 3'd1;
      else if (!accept && pop) rx_cnt <= rx_cnt - 3'd1;
    end
  end
`else
  logic [7:0] rx_data;
  logic       rx_full;

  assign rxav    = rx_full;
  assign rx_head = rx_data;
  assign accept  = push && (!rx_full || pop);
  assign overrun = push && rx_full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data <= 8'h00;
      rx_full <= 1'b0;
    end else if (accept) begin
      rx_data <= rx_byte;
      rx_full <= 1'b1;
    end else if (pop) begin
      rx_full <= 1'b0;
    end
  end
`endif

  assign spscon = {(state == SHIFT), ovr, txe, rxav, 1'b0, cpha, cpol, en};

  always_comb begin
    rd_data = 8'h00;
    if (loc_addr == AW'(0))      rd_data = spscon;
    else if (loc_addr == AW'(1)) rd_data = tx_buf;
    else if (loc_addr == AW'(2)) rd_data = rxav ? rx_head : 8'h00;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    dout <= 8'h00;
    else if (rd_act) dout <= rd_data;
  end

  assign miso    = (state == SHIFT) && miso_q;
  assign miso_oe = en && !ss_s2;

endmodule

// File: doc/spi_slave_top.md
# spi_slave_top

SPI slave peripheral for the TRSQ8 CPU I/O bus and the counterpart of the SPI master peripheral. An external master drives `sclk`, `mosi` and `ss_n`. The block shifts received bytes into an RX buffer and shifts bytes queued by the CPU out on `miso`, MSB first, in SPI modes 0–3. The CPU reaches it through the same 4-register window (addr/din/dout/wr_en/rd_en) as the other TRSQ8 peripherals.

## Interface
- `ADDR_LSB`, 0, LSB of the register select field in `addr`
- `OPT_MEM_ADDR_BITS`, 1, register select width minus 1; `loc_addr = addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB]`
- `clk`  in  1  system clock; all state changes on rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `addr`  in  8  CPU register address
- `din`  in  8  CPU write data
- `dout`  out  8  CPU read data, registered
- `wr_en`  in  1  CPU write strobe, 1 cycle
- `rd_en`  in  1  CPU read strobe, 1 cycle; `wr_en` has priority
- `sclk`  in  1  SPI clock from the master, asynchronous
- `mosi`  in  1  SPI data from the master, asynchronous
- `ss_n`  in  1  slave select, active-low, asynchronous
- `miso`  out  1  SPI data to the master
- `miso_oe`  out  1  pad enable for `miso`; 1 only while EN=1 and the synchronised `ss_n` is 0

## Operation
- Registers, selected by `loc_addr`:
  - 0 SPSCON:
    - b0 EN (rw)
    - b1 CPOL (rw)
    - b2 CPHA (rw)
    - b3 reserved, reads 0
    - b4 RXAV (ro): RX data available
    - b5 TXE (ro): TX buffer empty
    - b6 OVR: overrun; writing 1 clears it, writing 0 has no effect
    - b7 BUSY (ro): in SHIFT state
  - 1 SPSTX: write fills the TX buffer and clears TXE; read returns the last value written.
  - 2 SPSRX: read returns the oldest RX byte and pops it; returns 0x00 when RXAV=0; writes ignored.
  - 3: reads 0x00, writes ignored.
- `sclk`, `mosi` and `ss_n` each pass through a 2-flop synchroniser. Edges are detected on the synchronised `sclk`.
- Leading edge = `sclk` leaving the CPOL idle level; trailing edge = `sclk` returning to it.
- CPHA=0: sample `mosi` on leading edges, shift out on trailing edges.
- CPHA=1: shift out on leading edges, sample on trailing edges.
- FSM states:
  - IDLE: `miso`=0, bit counter=0. Moves to SHIFT when synchronised `ss_n` falls while EN=1.
  - SHIFT: on entry, load the shift register (load rule below). `miso` = shift-register MSB.
    - Each sample edge: shift `mosi` into the LSB and increment the 3-bit counter.
    - When the counter wraps from 7 to 0: push the byte to RX and reload the shift register for the next byte (continuous transfer).
    - Returns to IDLE when `ss_n` rises or EN is cleared. A partial byte is discarded, the counter is cleared, and nothing is pushed.
- Load rule: if TXE=0, load the TX buffer and set TXE=1; otherwise load 0x00.
- RX push when RX is full: byte dropped, OVR=1.
- CPOL/CPHA writes during SHIFT take effect at the next IDLE→SHIFT transition.

## Timing
- Reset values:
  - SPSCON=0x20 (TXE=1, all other bits 0)
  - TX buffer=0x00, RX empty
  - `dout`=0x00, `miso`=0, `miso_oe`=0
  - FSM in IDLE
- CPU read: `dout` is valid on the clock edge after `rd_en`. The pop happens on the same edge.
- CPU write: takes effect on the edge where `wr_en`=1.
- Latency: RXAV=1 three `clk` cycles after the final sampling `sclk` edge at the pin (2 synchroniser + 1).
- CHPA=0 first bit: `miso` shows the MSB 3 cycles after `ss_n` falls at the pin. The master must wait at least 4 `clk` cycles before its first `sclk` edge.
- Maximum `sclk` = `clk`/8; each `sclk` phase lasts at least 4 `clk` cycles.
- Simultaneous events:
  - TX write in the same cycle as a load: the load uses the old buffer state; the new byte stays buffered with TXE=0.
  - RX pop in the same cycle as an RX push: both happen, no overrun.
  - Clearing EN while `ss_n`=0: the FSM drops to IDLE on that edge and `miso_oe` falls on that edge.
- `reset_n` asserted mid-frame: immediate return to reset values. A new frame requires a fresh `ss_n` falling edge.

## Configuration
- `SPI_SLAVE_RXFIFO_EN` defined: RX storage is a 4-entry FIFO.
  - RXAV = not empty.
  - Overrun when a 5th byte arrives unread.
  - 2-bit read and write pointers wrap modulo 4, plus a count in the range 0–4.
- Not defined: RX storage is a single byte register.
  - RXAV = full.
  - Overrun when a 2nd byte arrives before it is read.

## Test plan
- Reset, then read addr 0 -> `dout`=0x20; read addr 2 -> 0x00; `miso_oe`=0.
- Mode 0, EN=1, write SPSTX=0xA5; master sends 0x3C at `clk`/8 -> master receives 0xA5; SPSRX=0x3C; RXAV=1; TXE=1; OVR=0.
- Mode 3 (CPOL=1, CPHA=1): master sends 0x81, 0x7E with `ss_n` held low; TX buffer empty -> master receives 0x00, 0x00; reads return 0x81 then 0x7E (with FIFO). Without FIFO, OVR=1 and the read returns 0x81.
- Master sends 5 bytes 0x01..0x05 without CPU reads -> with FIFO: OVR=1 and reads return 0x01..0x04. Without FIFO: OVR=1 and the read returns 0x01. Write SPSCON with b6=1 -> OVR=0.
- Raise `ss_n` after 5 bits -> no RX push; RXAV unchanged; BUSY=0. The next full byte 0x55 is received correctly.
- Assert `reset_n`=0 for 1 cycle mid-byte -> SPSCON=0x20 and `miso_oe`=0 immediately. No byte is received until `ss_n` toggles high then low again.
